// File: rtl/fx_reg_bank_if.sv
// fx-bus access port: one write channel, one read channel, registered read data.
// The master drives strobes, addresses and write data; the slave returns fx_q.
interface fx_reg_bank_if;
    logic        fx_wr;
    logic [21:0] fx_waddr;
    logic [7:0]  fx_data;
    logic        fx_rd;
    logic [21:0] fx_raddr;
    logic [7:0]  fx_q;

    modport master (
        output fx_wr, fx_waddr, fx_data, fx_rd, fx_raddr,
        input  fx_q
    );

    modport slave (
        input  fx_wr, fx_waddr, fx_data, fx_rd, fx_raddr,
        output fx_q
    );
endinterface

// File: rtl/fx_reg_bank.sv
// fx-bus register block: N_CFG 16-bit config registers with two-byte atomic commit,
// N_STU write-1-to-clear sticky status bits and a maskable registered interrupt.
module fx_reg_bank #(
    parameter int          N_CFG    = 4,
    parameter int          N_STU    = 8,
    parameter logic [15:0] CFG_BASE = 16'h0040,
    parameter logic [15:0] CFG_RST  = 16'h0030,
    parameter logic [7:0]  VERSION  = 8'h02
) (
    input  logic                 clk_sys,
    input  logic                 rst_n,
    input  logic [5:0]           dev_id,
    fx_reg_bank_if.slave         fx,
    input  logic [N_STU-1:0]     stu_event,
    output logic [16*N_CFG-1:0]  cfg_out,
    output logic [N_CFG-1:0]     cfg_upd,
    output logic                 irq
);
    localparam logic [15:0] OFF_ID      = 16'h0000;
    localparam logic [15:0] OFF_VERSION = 16'h0001;
    localparam logic [15:0] OFF_STICKY  = 16'h0010;
    localparam logic [15:0] OFF_LIVE    = 16'h0011;
    localparam logic [15:0] OFF_MASK    = 16'h0012;
    localparam logic [15:0] OFF_SCRATCH = 16'h0080;

    logic                   now_wr;
    logic                   now_rd;
    logic [15:0]            woff;
    logic [15:0]            roff;
    logic [N_CFG-1:0]       w_lo;
    logic [N_CFG-1:0]       w_hi;
    logic [N_CFG-1:0]       r_lo;
    logic [N_CFG-1:0]       r_hi;
    logic [N_CFG-1:0][15:0] cfg_q;
    logic [N_CFG-1:0][7:0]  wshadow;
    logic [7:0]             rshadow;
    logic [7:0]             scratch;
    logic [7:0]             rd_data;
    logic [N_STU-1:0]       sticky;
    logic [N_STU-1:0]       irq_mask;
    logic [N_STU-1:0]       sticky_nxt;
    logic [N_STU-1:0]       mask_nxt;
    logic [N_STU-1:0]       clr;

    assign now_wr  = fx.fx_wr && (fx.fx_waddr[21:16] == dev_id);
    assign now_rd  = fx.fx_rd && (fx.fx_raddr[21:16] == dev_id);
    assign woff    = fx.fx_waddr[15:0];
    assign roff    = fx.fx_raddr[15:0];
    assign cfg_out = cfg_q;

    // Per-register byte selects; register i owns CFG_BASE+2i (low) and +1 (high).
    for (genvar i = 0; i < N_CFG; i++) begin : g_dec
        localparam logic [15:0] LO_OFF = CFG_BASE + 16'(2 * i);
        localparam logic [15:0] HI_OFF = CFG_BASE + 16'(2 * i + 1);
        assign w_lo[i] = now_wr && (woff == LO_OFF);
        assign w_hi[i] = now_wr && (woff == HI_OFF);
        assign r_lo[i] = now_rd && (roff == LO_OFF);
        assign r_hi[i] = now_rd && (roff == HI_OFF);
    end

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        clr      = '0;
        mask_nxt = irq_mask;
        if (now_wr && (woff == OFF_STICKY)) clr      = fx.fx_data[N_STU-1:0];
        if (now_wr && (woff == OFF_MASK))   mask_nxt = fx.fx_data[N_STU-1:0];
        // A live event outranks a same-cycle clear of the same bit.
        sticky_nxt = stu_event | (sticky & ~clr);
    end

    // Read mux works on current state, so a same-cycle write is not visible yet.
    always_comb begin
        rd_data = '0;
        if (now_rd) begin
            case (roff)
                OFF_ID:      rd_data = {2'b00, dev_id};
                OFF_VERSION: rd_data = VERSION;
                OFF_STICKY:  rd_data = 8'(sticky);
                OFF_LIVE:    rd_data = 8'(stu_event);
                OFF_MASK:    rd_data = 8'(irq_mask);
                OFF_SCRATCH: rd_data = scratch;
                default:     rd_data = '0;
            endcase
            for (int i = 0; i < N_CFG; i++) begin
                if (r_lo[i]) rd_data = cfg_q[i][7:0];
                if (r_hi[i]) rd_data = rshadow;
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            // NOTE: the shadow arrays are reset too, so an aborted byte pair never leaks across reset.
            fx.fx_q  <= '0;
            cfg_q    <= {N_CFG{CFG_RST}};
            wshadow  <= '0;
            rshadow  <= '0;
            cfg_upd  <= '0;
            scratch  <= 8'h80;
            sticky   <= '0;
            irq_mask <= '0;
            irq      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            fx.fx_q  <= rd_data;
            cfg_upd  <= '0;
            sticky   <= sticky_nxt;
            irq_mask <= mask_nxt;
            irq      <= |(sticky_nxt & mask_nxt);
            if (now_wr && (woff == OFF_SCRATCH)) scratch <= fx.fx_data;
            for (int i = 0; i < N_CFG; i++) begin
                if (w_lo[i]) wshadow[i] <= fx.fx_data;
                if (w_hi[i]) begin
                    cfg_q[i]   <= {fx.fx_data, wshadow[i]};
                    cfg_upd[i] <= 1'b1;
                end
                if (r_lo[i]) rshadow <= cfg_q[i][15:8];
            end
        end
    end
endmodule

// File: tb/tb_fx_reg_bank.sv
// Self-checking bench for fx_reg_bank: read expectations are queued when a read is
// issued and popped when fx_q is sampled on the following falling edge.
module tb_fx_reg_bank;
    logic        clk_sys = 1'b0;
    logic        rst_n;
    logic [5:0]  dev_id;
    logic [7:0]  stu_event;
    logic [63:0] cfg_out;
    logic [3:0]  cfg_upd;
    logic        irq;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  got;
    logic [7:0]  exp;

    fx_reg_bank_if bus ();

    fx_reg_bank #(
        .N_CFG(4),
        .N_STU(8),
        .CFG_BASE(16'h0040),
        .CFG_RST(16'h0030),
        .VERSION(8'h02)
    ) dut (
        .clk_sys(clk_sys),
        .rst_n(rst_n),
        .dev_id(dev_id),
        .fx(bus.slave),
        .stu_event(stu_event),
        .cfg_out(cfg_out),
        .cfg_upd(cfg_upd),
        .irq(irq)
    );

    always #5 clk_sys = ~clk_sys;

    initial begin
        #200000;
        $display("FAIL watchdog expired: got timeout, expected summary");
        $fatal(1, "watchdog");
    end

    // One bus cycle, entered and left on a falling edge.
    task automatic bus_cycle(input logic w, input logic [21:0] wa, input logic [7:0] wd,
                             input logic r, input logic [21:0] ra);
        bus.fx_wr    = w;
        bus.fx_waddr = wa;
        bus.fx_data  = wd;
        bus.fx_rd    = r;
        bus.fx_raddr = ra;
        @(negedge clk_sys);
        bus.fx_wr = 1'b0;
        bus.fx_rd = 1'b0;
    endtask

    task automatic wr(input logic [21:0] a, input logic [7:0] d);
        bus_cycle(1'b1, a, d, 1'b0, 22'h0);
    endtask

    task automatic rd(input logic [21:0] a, input logic [7:0] e);
        exp_q.push_back(e);
        bus_cycle(1'b0, 22'h0, 8'h00, 1'b1, a);
    endtask

    task automatic test_reset();
        logic [21:0] a [4] = '{22'h050000, 22'h050001, 22'h050040, 22'h050041};
        logic [7:0]  e [4] = '{8'h05, 8'h02, 8'h30, 8'h00};
        checks++;
        if (bus.fx_q !== 8'h00 || cfg_out !== {4{16'h0030}} || cfg_upd !== 4'h0 || irq !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got q=%h cfg=%h upd=%b irq=%b exp q=00 cfg=%h upd=0000 irq=0",
                     bus.fx_q, cfg_out, cfg_upd, irq, {4{16'h0030}});
        end
        for (int i = 0; i < 4; i++) begin
            rd(a[i], e[i]);
            got = bus.fx_q; exp = exp_q.pop_front(); checks++;
            if (got !== exp) begin errors++; $display("FAIL reset_rd%0d got %h exp %h", i, got, exp); end
        end
        @(negedge clk_sys);
        checks++;
        if (bus.fx_q !== 8'h00) begin errors++; $display("FAIL idle_q got %h exp 00", bus.fx_q); end
    endtask

    task automatic test_cfg_write();
        wr(22'h050042, 8'h34);
        checks++;
        if (cfg_out[31:16] !== 16'h0030 || cfg_upd !== 4'b0000) begin
            errors++; $display("FAIL cfg_lo_only got %h upd %b exp 0030 upd 0000", cfg_out[31:16], cfg_upd);
        end
        wr(22'h050043, 8'h12);
        checks++;
        if (cfg_out[31:16] !== 16'h1234 || cfg_upd !== 4'b0010) begin
            errors++; $display("FAIL cfg_commit got %h upd %b exp 1234 upd 0010", cfg_out[31:16], cfg_upd);
        end
        @(negedge clk_sys);
        checks++;
        if (cfg_upd !== 4'b0000) begin errors++; $display("FAIL cfg_upd_width got %b exp 0000", cfg_upd); end
    endtask

    task automatic test_misc();
        wr(22'h060080, 8'h11);
        rd(22'h050080, 8'h80);
        got = bus.fx_q; exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL wr_miss got %h exp %h", got, exp); end
        rd(22'h050099, 8'h00);
        got = bus.fx_q; exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL unmapped got %h exp %h", got, exp); end
        rd(22'h060001, 8'h00);
        got = bus.fx_q; exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL rd_miss got %h exp %h", got, exp); end
        exp_q.push_back(8'h80);
        bus_cycle(1'b1, 22'h050080, 8'h5A, 1'b1, 22'h050080);
        got = bus.fx_q; exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL rw_same got %h exp %h", got, exp); end
        rd(22'h050080, 8'h5A);
        got = bus.fx_q; exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL scratch got %h exp %h", got, exp); end
        wr(22'h050001, 8'hFF);
        rd(22'h050001, 8'h02);
        got = bus.fx_q; exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL ro_write got %h exp %h", got, exp); end
    endtask

    task automatic test_status();
        stu_event = 8'h05;
        @(negedge clk_sys);
        stu_event = 8'h00;
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_masked got %b exp 0", irq); end
        rd(22'h050010, 8'h05);
        got = bus.fx_q; exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL sticky_set got %h exp %h", got, exp); end
        rd(22'h050011, 8'h00);
        got = bus.fx_q; exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL live got %h exp %h", got, exp); end
        wr(22'h050012, 8'h04);
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL irq_unmask got %b exp 1", irq); end
        wr(22'h050010, 8'h04);
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_clear got %b exp 0", irq); end
        rd(22'h050010, 8'h01);
        got = bus.fx_q; exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL w1c got %h exp %h", got, exp); end
        stu_event = 8'h01;
        wr(22'h050010, 8'h01);
        stu_event = 8'h00;
        rd(22'h050010, 8'h01);
        got = bus.fx_q; exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL set_wins got %h exp %h", got, exp); end
        stu_event = 8'h04;
        @(negedge clk_sys);
        stu_event = 8'h00;
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL irq_latency got %b exp 1", irq); end
        wr(22'h050012, 8'h00);
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_mask_off got %b exp 0", irq); end
        wr(22'h050010, 8'hFF);
        rd(22'h050010, 8'h00);
        got = bus.fx_q; exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL clear_all got %h exp %h", got, exp); end
    endtask

    task automatic test_coherent();
        wr(22'h050040, 8'hCD);
        wr(22'h050041, 8'hAB);
        rd(22'h050040, 8'hCD);
        got = bus.fx_q; exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL coh_lo got %h exp %h", got, exp); end
        wr(22'h050040, 8'h11);
        wr(22'h050041, 8'h11);
        checks++;
        if (cfg_out[15:0] !== 16'h1111) begin errors++; $display("FAIL coh_commit got %h exp 1111", cfg_out[15:0]); end
        rd(22'h050041, 8'hAB);
        got = bus.fx_q; exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL coh_snapshot got %h exp %h", got, exp); end
        rd(22'h050040, 8'h11);
        got = bus.fx_q; exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL fresh_lo got %h exp %h", got, exp); end
        rd(22'h050041, 8'h11);
        got = bus.fx_q; exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL fresh_hi got %h exp %h", got, exp); end
    endtask

    task automatic test_back_to_back();
        logic [21:0] a [3] = '{22'h050000, 22'h050080, 22'h050012};
        logic [7:0]  e [3] = '{8'h05, 8'h5A, 8'h00};
        for (int i = 0; i < 3; i++) begin
            bus.fx_rd    = 1'b1;
            bus.fx_raddr = a[i];
            exp_q.push_back(e[i]);
            @(negedge clk_sys);
            got = bus.fx_q; exp = exp_q.pop_front(); checks++;
            if (got !== exp) begin errors++; $display("FAIL b2b_rd%0d got %h exp %h", i, got, exp); end
        end
        bus.fx_rd = 1'b0;
        @(negedge clk_sys);
        checks++;
        if (bus.fx_q !== 8'h00) begin errors++; $display("FAIL b2b_idle got %h exp 00", bus.fx_q); end
    endtask

    task automatic test_reset_mid();
        wr(22'h050040, 8'h55);
        rst_n = 1'b0;
        @(negedge clk_sys);
        checks++;
        if (cfg_upd !== 4'b0000 || cfg_out !== {4{16'h0030}}) begin
            errors++; $display("FAIL mid_reset got cfg %h upd %b exp %h upd 0000", cfg_out, cfg_upd, {4{16'h0030}});
        end
        rst_n = 1'b1;
        wr(22'h050041, 8'h66);
        checks++;
        if (cfg_out[15:0] !== 16'h6600 || cfg_upd !== 4'b0001) begin
            errors++; $display("FAIL shadow_discard got %h upd %b exp 6600 upd 0001", cfg_out[15:0], cfg_upd);
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        dev_id       = 6'h05;
        stu_event    = 8'h00;
        bus.fx_wr    = 1'b0;
        bus.fx_waddr = 22'h0;
        bus.fx_data  = 8'h00;
        bus.fx_rd    = 1'b0;
        bus.fx_raddr = 22'h0;
        repeat (3) @(negedge clk_sys);
        rst_n = 1'b1;
        @(negedge clk_sys);

        test_reset();
        test_cfg_write();
        test_misc();
        test_status();
        test_coherent();
        test_back_to_back();
        test_reset_mid();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fx_reg_bank.md
Name: fx_reg_bank

Overview:
Parametrised successor of the per-application fx-bus register block. It decodes fx-bus accesses whose address bits [21:16] match dev_id. It holds N_CFG 16-bit configuration registers with atomic two-byte commit, and captures N_STU status channels into write-1-to-clear sticky bits with a maskable interrupt. Each application top instantiates one copy on clk_sys.

Parameters:
N_CFG, 4, number of 16-bit config registers (1..32)
N_STU, 8, number of status channels (1..8)
CFG_BASE, 16'h0040, offset of config register 0 low byte; register i occupies CFG_BASE+2i (low) and CFG_BASE+2i+1 (high)
CFG_RST, 16'h0030, reset value of every config register
VERSION, 8'h02, value returned at offset 0x0001

Ports:
clk_sys  in  1  system clock, all logic on rising edge
rst_n  in  1  reset, synchronous, active-low
dev_id  in  6  block select, compared with fx_waddr/fx_raddr [21:16]
fx_wr  in  1  write strobe, one access per cycle high
fx_waddr  in  22  write address: [21:16] device, [15:0] offset
fx_data  in  8  write data
fx_rd  in  1  read strobe
fx_raddr  in  22  read address
fx_q  out  8  read data, registered
stu_event  in  N_STU  live status inputs, level-sensitive
cfg_out  out  16*N_CFG  committed config values; register i on bits [16i+15:16i]
cfg_upd  out  N_CFG  one-cycle pulse when register i commits
irq  out  1  registered OR of (sticky & irq_mask)

Behaviour:
- The clock is clk_sys. Reset rst_n is synchronous and active-low, sampled on the clk_sys edge. There is no asynchronous reset path.
- Reset values: fx_q=0, cfg_out=all CFG_RST, cfg_upd=0, irq=0. Sticky=0, irq_mask=0, scratch=8'h80. All write and read shadows=0.
- Write hit: now_wr = fx_wr & (fx_waddr[21:16]==dev_id). Read hit: now_rd = fx_rd & (fx_raddr[21:16]==dev_id). Writes that miss have no effect.
- Offset map:
  - 0x0000 R: {2'b0,dev_id}
  - 0x0001 R: VERSION
  - 0x0010 R/W1C: sticky status
  - 0x0011 R: live stu_event
  - 0x0012 R/W: irq_mask
  - 0x0080 R/W: scratch
  - config region
  - Status values are zero-extended to 8 bits. Unused upper write bits are ignored.
- Config write:
  - Write to the low byte loads wshadow[i]. cfg_out[i] does not change.
  - Write to the high byte commits {fx_data, wshadow[i]} to cfg_out[i] on the same edge and pulses cfg_upd[i] for exactly one cycle.
  - Writing only the high byte commits the stale shadow; this is intended.
- Config read:
  - Low-byte read returns committed low byte and snapshots committed high byte into rshadow (single shared shadow).
  - High-byte read returns rshadow, not the live value. This gives a coherent 16-bit read across a concurrent commit.
- Read latency: fx_q is updated on the edge after now_rd and is 0 in every cycle with no read hit. Unmapped offsets read 0.
- Read/write same cycle, same offset: fx_q returns the pre-write value.
- Sticky status, per bit per cycle: next = stu_event | (sticky & ~clr), where clr = fx_data on a write hit to 0x0010, else 0. Set wins over a same-cycle clear.
- irq registers |(next sticky & next irq_mask), one cycle after the cause. It deasserts the cycle after the cause is cleared or masked.
- Writes to read-only offsets are ignored. Reads have no side effects except the rshadow snapshot.
- Reset asserted mid-sequence discards pending wshadow/rshadow contents. No cfg_upd pulse is issued.

Test Plan:
- Reset, dev_id=6'h05, read 0x050000, 0x050001, 0x050040, 0x050041 -> fx_q one cycle after each read = 8'h05, 8'h02, 8'h30, 8'h00. fx_q=0 in idle cycles.
- Write 0x050042=8'h34 -> cfg_out[1] still 16'h0030. Then write 0x050043=8'h12 -> cfg_out[1]=16'h1234 and cfg_upd=4'b0010 for exactly one cycle.
- Write with fx_waddr[21:16]=6'h06 to 0x0080 -> scratch stays 8'h80. Read of an unmapped offset 0x0099 -> fx_q=0.
- Pulse stu_event=8'h05 one cycle -> sticky reads 8'h05, live reads 8'h00. Write irq_mask=8'h04 -> irq=1. Write 0x0010=8'h04 -> sticky=8'h01, irq=0. Clear with stu_event[0] held high -> bit 0 remains set.
- Read 0x0040 (cfg0=16'hABCD), then commit 16'h1111 to cfg0, then read 0x0041 -> fx_q=8'hAB (snapshot). A fresh low/high read pair returns 8'h11, 8'h11.
- Write 0x0040=8'h55, assert rst_n=0 for one cycle, then write 0x0041=8'h66 -> cfg_out[0]=16'h6600 and no cfg_upd during reset.
